instr_dispatcher: RTL and testbench
===================================

Name: instr_dispatcher

Overview:
Instruction queue and issue sequencer in front of the matrix coprocessor core (FETCH/DECODE/MEMORY/EXECUTE FSM).
- Accepts 32-bit instructions from the host through a valid/ready handshake and buffers them in a small FIFO.
- Screens opcodes, then issues one instruction at a time to the core as a one-cycle activate pulse. Waits for the core's completion pulse before issuing the next.
- Reports occupancy, completions and errors back to the host.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
CNT_W, 8, width of completion/drop counters
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
instr_in  in  32  host instruction; opcode in bits [3:0]
instr_valid  in  1  host offers instr_in
instr_ready  out  1  dispatcher can accept; = !full && !flush
flush  in  1  discard all queued (not in-flight) entries
cop_instruction  out  32  instruction presented to the core
cop_activate  out  1  one-cycle issue strobe to the core
cop_done  in  1  one-cycle pulse: core has returned to FETCH
busy  out  1  state != IDLE or FIFO not empty
fifo_count  out  $clog2(DEPTH)+1  entries queued
done_count  out  CNT_W  instructions completed, wraps
drop_count  out  CNT_W  illegal instructions dropped, wraps
err_illegal  out  1  sticky illegal-opcode flag
err_timeout  out  1  sticky watchdog flag
err_clear  in  1  clears both sticky flags

Behaviour:
- Reset (reset_n=0 at a clock edge): FIFO empty, state IDLE, cop_instruction=0, cop_activate=0, counters 0, flags 0, instr_ready=0 during reset.
- FIFO: read/write pointers carry one extra wrap bit. Full when indices match and wrap bits differ. Push when instr_valid && instr_ready. fifo_count updates the cycle after the push/pop edge.
- Push and pop in the same cycle are both performed, and the count is unchanged.
- The FIFO has no bypass path.
- Legal opcodes: 1 (READ), 2 (WRITE), 3..12 (SUM..DET5). Opcodes 0, 13, 14, 15 are illegal.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, FIFO non-empty: pop the head.
  - Illegal head: drop_count+1, err_illegal=1, remain IDLE. The next pop is allowed the following cycle.
  - Legal head: load cop_instruction, go to ISSUE.
- ISSUE: cop_activate=1 for exactly this cycle, then go to WAIT.
- WAIT: cop_instruction held stable. On cop_done, done_count+1 and go to IDLE.
- cop_done in IDLE or ISSUE is ignored and not counted.
- Latency: for a push accepted at edge t into an empty FIFO with the FSM in IDLE, the pop occurs at edge t+1 and cop_activate is high in the cycle after edge t+2.
- Back-to-back: minimum 3 cycles between consecutive cop_activate pulses (IDLE, ISSUE, WAIT + done).
- cop_instruction keeps its last value in IDLE; it is not cleared.
- flush: empties the FIFO at the next edge and forces instr_ready low in the same cycle, so a simultaneous push is not accepted.
  - flush does not abort ISSUE/WAIT; the in-flight instruction completes normally.
  - flush in IDLE with a non-empty FIFO: flush wins, nothing is popped.
- err_clear with a simultaneous set condition: set wins.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-WAIT: returns to IDLE immediately. A later cop_done from the core is ignored.

Optional Feature:
TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without cop_done:
  - err_timeout=1, return to IDLE, done_count unchanged.
  - A cop_done arriving in that same cycle takes priority: it counts as completion and no timeout is flagged.
- Undefined: no counter logic; err_timeout tied to 0. WAIT lasts until cop_done.

Test Plan:
- Reset, then push 0x00000003 into an empty FIFO at edge t → single cop_activate pulse in the cycle after t+2 with cop_instruction=0x00000003. cop_done after 5 cycles → done_count=1, busy=0.
- Push 5 legal instructions with DEPTH=4 and the core stalled (no cop_done) → first issues; the next 4 fill the FIFO; instr_ready=0 at fifo_count=4; a 6th push is held off until cop_done.
- Push opcodes 0x0, 0xD, 0x2 → drop_count=2, err_illegal=1, only 0x2 issued. err_clear while no illegal pop → err_illegal=0.
- Queue 3 entries during WAIT, assert flush together with instr_valid → fifo_count=0, push not accepted, in-flight instruction still completes on cop_done.
- Deassert reset_n during WAIT, then pulse cop_done after reset → all outputs at reset values, done_count stays 0.
- TIMEOUT_EN with TIMEOUT_CYCLES=8, no cop_done → err_timeout=1 after 8 WAIT cycles, FSM back to IDLE. Repeat with cop_done on cycle 8 → no flag, done_count+1.

Source files
------------

// File: rtl/instr_dispatcher.sv
// instr_dispatcher: host-facing instruction FIFO and issue sequencer for the
// matrix coprocessor core. Instructions are queued, opcode-screened, and issued
// one at a time as a single-cycle activate strobe. The next instruction is
// issued only after the core reports completion.
// Optional feature: define TIMEOUT_EN to add a watchdog on the WAIT state.
// Without it, err_timeout is tied low and WAIT lasts until cop_done.
module instr_dispatcher #(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              instr_in,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     flush,
  output logic [31:0]              cop_instruction,
  output logic                     cop_activate,
  input  logic                     cop_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         done_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     err_illegal,
  output logic                     err_timeout,
  input  logic                     err_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Elaboration-time guard on the configuration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("instr_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Opcodes 1..12 (READ, WRITE, SUM..DET5) are accepted; 0 and 13..15 are not.
  function automatic logic opcode_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd12);
  endfunction

  // FIFO storage and pointers (one extra wrap bit each)
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_s, empty_s, push_s, pop_s;
  logic [31:0]   head_s;

  // Sequencer state and host-visible registers
  state_e           state_q, state_d;
  logic [31:0]      cop_instr_q, cop_instr_d;
  logic             cop_act_q, cop_act_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             err_ill_q, err_ill_d;
  logic             ill_set_s;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_tmo_q, err_tmo_d;
  logic          tmo_set_s;
`endif

  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

  // Flush blocks both the push side and the pop side in its cycle.
  assign instr_ready = reset_n && !full_s && !flush;
  assign push_s      = instr_valid && instr_ready;
  assign pop_s       = (state_q == ST_IDLE) && !empty_s && !flush;

  assign fifo_count      = wr_ptr_q - rd_ptr_q;
  assign busy            = (state_q != ST_IDLE) || !empty_s;
  assign cop_instruction = cop_instr_q;
  assign cop_activate    = cop_act_q;
  assign done_count      = done_cnt_q;
  assign drop_count      = drop_cnt_q;
  assign err_illegal     = err_ill_q;
`ifdef TIMEOUT_EN
  assign err_timeout     = err_tmo_q;
`else
  assign err_timeout     = 1'b0;
`endif

  // Next FIFO pointers: flush snaps the read pointer onto the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Sequencer next state, issue strobe, counters and flag set conditions.
  always_comb begin
    state_d     = state_q;
    cop_instr_d = cop_instr_q;
    cop_act_d   = 1'b0;
    done_cnt_d  = done_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ill_set_s   = 1'b0;
`ifdef TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_set_s   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          if (opcode_legal(head_s[3:0])) begin
            cop_instr_d = head_s;
            state_d     = ST_ISSUE;
          end else begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
            ill_set_s  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cop_act_d = 1'b1;
        state_d   = ST_WAIT;
`ifdef TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (cop_done) begin
          done_cnt_d = done_cnt_q + CNT_ONE;
          state_d    = ST_IDLE;
        end else begin
`ifdef TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            tmo_set_s = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky illegal flag: a set in the same cycle beats err_clear.
  always_comb begin
    if (ill_set_s) begin
      err_ill_d = 1'b1;
    end else if (err_clear) begin
      err_ill_d = 1'b0;
    end else begin
      err_ill_d = err_ill_q;
    end
  end

`ifdef TIMEOUT_EN
  // Sticky timeout flag: a set in the same cycle beats err_clear.
  always_comb begin
    if (tmo_set_s) begin
      err_tmo_d = 1'b1;
    end else if (err_clear) begin
      err_tmo_d = 1'b0;
    end else begin
      err_tmo_d = err_tmo_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end
`endif

  // FIFO storage write; cleared on reset so the head is never unknown.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= instr_in;
    end
  end

  // Pointer, FSM, counter and flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      cop_instr_q <= 32'd0;
      cop_act_q   <= 1'b0;
      done_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      err_ill_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      cop_instr_q <= cop_instr_d;
      cop_act_q   <= cop_act_d;
      done_cnt_q  <= done_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_ill_q   <= err_ill_d;
    end
  end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Testbench for instr_dispatcher: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level reference model
// (a queue of pending instructions plus an in-flight slot).
module tb_instr_dispatcher;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        flush = 1'b0;
  logic [31:0] cop_instruction;
  logic        cop_activate;
  logic        cop_done = 1'b0;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [7:0]  done_count;
  logic [7:0]  drop_count;
  logic        err_illegal;
  logic        err_timeout;
  logic        err_clear = 1'b0;

  instr_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .cop_instruction(cop_instruction),
    .cop_activate(cop_activate), .cop_done(cop_done), .busy(busy),
    .fifo_count(fifo_count), .done_count(done_count), .drop_count(drop_count),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_q[$];
  int          m_phase;   // 0: nothing in flight, 1: popped, strobe next, 2: core working
  logic [31:0] m_instr;
  bit          m_act;
  int          m_done, m_drop, m_wcnt;
  bit          m_ill, m_tmo;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] ins);
    return (ins[3:0] >= 4'd1) && (ins[3:0] <= 4'd12);
  endfunction

  // Apply one edge worth of the spec rules to the model.
  task automatic model_step();
    bit push, pop, set_ill, set_tmo;
    logic [31:0] head;
    if (!reset_n) begin
      m_q.delete();
      m_phase = 0; m_instr = 32'd0; m_act = 1'b0;
      m_done = 0; m_drop = 0; m_wcnt = 0; m_ill = 1'b0; m_tmo = 1'b0;
    end else begin
      push = instr_valid && (m_q.size() < DEPTH) && !flush;
      pop  = (m_phase == 0) && (m_q.size() > 0) && !flush;
      set_ill = 1'b0; set_tmo = 1'b0; m_act = 1'b0;
      if (m_phase == 2) begin
        if (cop_done) begin
          m_done++; m_phase = 0;
        end else begin
`ifdef TIMEOUT_EN
          m_wcnt++;
          if (m_wcnt == TMO) begin set_tmo = 1'b1; m_phase = 0; end
`endif
        end
      end else if (m_phase == 1) begin
        m_phase = 2; m_act = 1'b1; m_wcnt = 0;
      end else if (pop) begin
        head = m_q.pop_front();
        if (legal(head)) begin m_instr = head; m_phase = 1; end
        else begin m_drop++; set_ill = 1'b1; end
      end
      if (flush) m_q.delete();
      else if (push) m_q.push_back(instr_in);
      if (set_ill) m_ill = 1'b1; else if (err_clear) m_ill = 1'b0;
      if (set_tmo) m_tmo = 1'b1; else if (err_clear) m_tmo = 1'b0;
    end
  endtask

  task automatic check_all();
    check_eq("cop_activate", {31'd0, cop_activate}, {31'd0, m_act});
    check_eq("cop_instruction", cop_instruction, m_instr);
    check_eq("fifo_count", {29'd0, fifo_count}, m_q.size());
    check_eq("busy", {31'd0, busy}, {31'd0, (m_phase != 0) || (m_q.size() > 0)});
    check_eq("done_count", {24'd0, done_count}, m_done % 256);
    check_eq("drop_count", {24'd0, drop_count}, m_drop % 256);
    check_eq("err_illegal", {31'd0, err_illegal}, {31'd0, m_ill});
    check_eq("err_timeout", {31'd0, err_timeout}, {31'd0, m_tmo});
    check_eq("instr_ready", {31'd0, instr_ready},
             {31'd0, reset_n && (m_q.size() < DEPTH) && !flush});
  endtask

  // One clock: drive on the falling edge, model and check just after the rising edge.
  task automatic cycle(input bit v, input logic [31:0] d, input bit dn,
                       input bit fl, input bit clr, input bit rst);
    @(negedge clk);
    instr_valid = v; instr_in = d; cop_done = dn; flush = fl; err_clear = clr; reset_n = !rst;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int done_pct;
    logic [31:0] r;
    // Reset state.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single instruction latency, then completion five cycles later.
    cycle(1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);   // push at edge t
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);           // pop at t+1
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);           // strobe after t+2
    check_eq("latency_activate", {31'd0, cop_activate}, 32'd1);
    check_eq("latency_instr", cop_instruction, 32'h0000_0003);
    idle(4);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("first_done", {24'd0, done_count}, 32'd1);
    check_eq("first_idle", {31'd0, busy}, 32'd0);

    // Fill the FIFO with the core stalled; a sixth push waits for cop_done.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h100 + i * 16 + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("full_ready", {31'd0, instr_ready}, 32'd0);
    cycle(1'b1, 32'h0000_0165, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b0, 32'd0, (i % 4) == 3, 1'b0, 1'b0, 1'b0);

    // Illegal opcodes dropped, then err_clear.
    cycle(1'b1, 32'hABCD_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h1234_000D, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Queue during WAIT, flush together with a push, in-flight still completes.
    cycle(1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_0004 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0009, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset during WAIT, then a stray cop_done.
    cycle(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("reset_done_ignored", {24'd0, done_count}, 32'd0);

`ifdef TIMEOUT_EN
    // Watchdog fires with no cop_done, then cop_done on the last WAIT cycle wins.
    cycle(1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(14);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(9);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
`endif

    // Randomized traffic in segments with different core response rates.
    for (int seg = 0; seg < 24; seg++) begin
      case (seg % 4)
        0: done_pct = 0;
        1: done_pct = 15;
        2: done_pct = 50;
        default: done_pct = 95;
      endcase
      for (int i = 0; i < 250; i++) begin
        r = $urandom;
        cycle($urandom_range(99) < 60, r, $urandom_range(99) < done_pct,
              $urandom_range(99) < 2, $urandom_range(99) < 3,
              $urandom_range(999) < 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
